// File: rtl/icache_pkg.sv
// Shared bus widths and FSM encoding for the instruction cache.
package icache_pkg;
   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam int ByteW       = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      DONE   = 2'd2
   } icache_state_e;
endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line storage: tag, data and valid bit per line.
// Combinational read so hit/miss is known in the request cycle; valid bits clear asynchronously.
module icache_mem
   import icache_pkg::*;
#(
   parameter int INDEX_W = 7,
   parameter int TAG_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] rd_index_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [InstBus-1:0] rd_data_o,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [InstBus-1:0] wr_data_i
);
   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [InstBus-1:0] data_q [LINES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // Tag/data need no reset: a line is never used until its valid bit is set.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];
endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache, one word per line,
// refilled byte-by-byte from the memory controller.
module icache
   import icache_pkg::*;
#(
   parameter int ADDR_W  = 17,
   parameter int INDEX_W = 7
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [InstAddrBus-1:0] req_addr_i,
   output logic                   resp_valid_o,
   output logic [InstBus-1:0]     resp_inst_o,
   input  logic                   flush_i,
   output logic                   mc_req_o,
   input  logic                   mc_gnt_i,
   output logic [InstAddrBus-1:0] mc_addr_o,
   input  logic                   mc_rvalid_i,
   input  logic [ByteW-1:0]       mc_data_i
);
   localparam int TAG_W = ADDR_W - INDEX_W - 2;

   icache_state_e          state_q, state_d;
   logic [InstAddrBus-1:2] addr_q, addr_d;
   logic [2:0]             issue_q, issue_d;
   logic [2:0]             recv_q, recv_d;
   logic [InstBus-1:0]     buf_q, buf_d;
   logic                   drop_q, drop_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [InstBus-1:0]     resp_inst_q, resp_inst_d;

   logic                   rd_valid;
   logic [TAG_W-1:0]       rd_tag;
   logic [InstBus-1:0]     rd_data;
   logic                   line_we;
   logic                   hit;
   logic                   accept;
   logic                   grant;
   logic                   byte_in;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{req_addr_i[InstAddrBus-1:ADDR_W], req_addr_i[1:0]};

   icache_mem #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_mem (
      .clk_i      (clk_in),
      .rst_i      (rst_in),
      .rd_index_i (req_addr_i[INDEX_W+1:2]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (line_we),
      .wr_index_i (addr_q[INDEX_W+1:2]),
      .wr_tag_i   (addr_q[ADDR_W-1:INDEX_W+2]),
      .wr_data_i  (buf_q)
   );

   assign req_ready_o  = (state_q == IDLE) && !flush_i && rdy_in && !rst_in;
   assign resp_valid_o = resp_valid_q && !flush_i;
   assign resp_inst_o  = resp_inst_q;
   assign mc_req_o     = (state_q == REFILL) && (issue_q < 3'd4);
   assign mc_addr_o    = {addr_q, issue_q[1:0]};

   assign hit     = rd_valid && (rd_tag == req_addr_i[ADDR_W-1:INDEX_W+2]);
   assign accept  = req_valid_i && req_ready_o;
   assign grant   = mc_req_o && mc_gnt_i;
   // Only bytes we actually asked for count; anything beyond that is a stale return.
   assign byte_in = (state_q == REFILL) && mc_rvalid_i && (recv_q < issue_q);
   assign line_we = (state_q == DONE) && rdy_in;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_d      = issue_q;
      recv_d       = recv_q;
      buf_d        = buf_q;
      drop_d       = drop_q;
      resp_valid_d = 1'b0;
      resp_inst_d  = resp_inst_q;
      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (accept) begin
               if (hit) begin
                  resp_valid_d = 1'b1;
                  resp_inst_d  = rd_data;
               end else begin
                  state_d = REFILL;
                  addr_d  = req_addr_i[InstAddrBus-1:2];
                  issue_d = 3'd0;
                  recv_d  = 3'd0;
               end
            end
         end
         REFILL: begin
            if (flush_i) drop_d = 1'b1;
            if (grant) issue_d = issue_q + 3'd1;
            if (byte_in) begin
               buf_d[{recv_q[1:0], 3'b000} +: 8] = mc_data_i;
               recv_d = recv_q + 3'd1;
               if (recv_q == 3'd3) begin
                  state_d      = DONE;
                  resp_valid_d = !(drop_q || flush_i);
                  resp_inst_d  = {mc_data_i, buf_q[23:0]};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         issue_q      <= 3'd0;
         recv_q       <= 3'd0;
         buf_q        <= '0;
         drop_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_inst_q  <= '0;
      end else if (rdy_in) begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_q      <= issue_d;
         recv_q       <= recv_d;
         buf_q        <= buf_d;
         drop_q       <= drop_d;
         resp_valid_q <= resp_valid_d;
         resp_inst_q  <= resp_inst_d;
      end
   end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level cache model and a behavioural memory controller.
`timescale 1ns/1ps
module tb_icache;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        req_valid_i, req_ready_o;
   logic [31:0] req_addr_i;
   logic        resp_valid_o;
   logic [31:0] resp_inst_o;
   logic        flush_i;
   logic        mc_req_o, mc_gnt_i;
   logic [31:0] mc_addr_o;
   logic        mc_rvalid_i;
   logic [7:0]  mc_data_i;

   always #5 clk_in = ~clk_in;

   icache #(.ADDR_W(17), .INDEX_W(7)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .resp_valid_o (resp_valid_o),
      .resp_inst_o  (resp_inst_o),
      .flush_i      (flush_i),
      .mc_req_o     (mc_req_o),
      .mc_gnt_i     (mc_gnt_i),
      .mc_addr_o    (mc_addr_o),
      .mc_rvalid_i  (mc_rvalid_i),
      .mc_data_i    (mc_data_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] ram [0:131071];

   // Transaction-level model: which lines are cached, and what is in flight.
   bit          m_valid [128];
   logic [7:0]  m_tag   [128];
   bit          miss_active, done_cycle, drop, resp_pending;
   logic [31:0] resp_data, miss_addr;
   int          grants, returns;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } ret_t;
   ret_t ret_q[$];

   int  cyc = 0;
   int  last_due = 0;
   bit  rand_mem = 0;
   bit  stray = 0;
   bit  force_stray = 0;
   int  resp_cnt = 0;
   int  last_resp_cyc = 0;
   int  acc_cyc = 0;
   int  mc_req_cycles = 0;
   logic [31:0] last_resp_data = '0;

   bit          exp_ready, exp_mcreq, m_gnt, m_rv, m_hit;
   logic [31:0] m_a;
   int          m_due;
   ret_t        m_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      logic [16:0] b;
      b = {a[16:2], 2'b00};
      return {ram[b + 17'd3], ram[b + 17'd2], ram[b + 17'd1], ram[b]};
   endfunction

   always @(posedge clk_in) cyc <= cyc + 1;

   // Memory controller: grants (always or random), returns bytes in order after a delay.
   initial begin
      mc_gnt_i = 1'b0;
      mc_rvalid_i = 1'b0;
      mc_data_i = 8'h00;
      forever begin
         @(posedge clk_in);
         #1;
         mc_gnt_i    = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
         mc_rvalid_i = 1'b0;
         mc_data_i   = 8'h00;
         stray       = 1'b0;
         if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            mc_rvalid_i = 1'b1;
            m_a         = ret_q[0].addr;
            mc_data_i   = ram[m_a[16:0]];
         end else if (!miss_active && (force_stray || (rand_mem && $urandom_range(0, 19) == 0))) begin
            mc_rvalid_i = 1'b1;
            mc_data_i   = 8'($urandom);
            stray       = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, then advance the model across the coming edge.
   always @(negedge clk_in) begin
      if (mc_req_o) mc_req_cycles++;
      if (rst_in) begin
         check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
         check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
         check("rst_resp_inst", resp_inst_o, 32'd0);
         check("rst_mc_req", {31'd0, mc_req_o}, 32'd0);
         check("rst_mc_addr", mc_addr_o, 32'd0);
         for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
         miss_active  = 1'b0;
         done_cycle   = 1'b0;
         drop         = 1'b0;
         resp_pending = 1'b0;
         last_due     = 0;
         ret_q.delete();
      end else begin
         exp_ready = !miss_active && !done_cycle && !flush_i && rdy_in;
         exp_mcreq = miss_active && (grants < 4);
         check("req_ready", {31'd0, req_ready_o}, {31'd0, exp_ready});
         check("mc_req", {31'd0, mc_req_o}, {31'd0, exp_mcreq});
         if (exp_mcreq) check("mc_addr", mc_addr_o, miss_addr + 32'(grants));
         check("resp_valid", {31'd0, resp_valid_o}, {31'd0, resp_pending && !flush_i});
         if (resp_pending && !flush_i && resp_valid_o) check("resp_inst", resp_inst_o, resp_data);
         if (resp_valid_o && rdy_in) begin
            resp_cnt++;
            last_resp_cyc  = cyc;
            last_resp_data = resp_inst_o;
         end
         if (rdy_in) begin
            m_gnt        = exp_mcreq && mc_gnt_i;
            m_rv         = mc_rvalid_i && !stray;
            done_cycle   = 1'b0;
            resp_pending = 1'b0;
            if (exp_ready && req_valid_i) begin
               acc_cyc = cyc;
               m_a     = req_addr_i;
               m_hit   = m_valid[m_a[8:2]] && (m_tag[m_a[8:2]] == m_a[16:9]);
               if (m_hit) begin
                  resp_pending = 1'b1;
                  resp_data    = ram_word(m_a);
               end else begin
                  miss_active = 1'b1;
                  miss_addr   = {m_a[31:2], 2'b00};
                  grants      = 0;
                  returns     = 0;
                  drop        = 1'b0;
               end
            end else if (miss_active) begin
               if (flush_i) drop = 1'b1;
               if (m_gnt) begin
                  m_due = cyc + 1 + (rand_mem ? int'($urandom_range(0, 2)) : 0);
                  if (m_due <= last_due) m_due = last_due + 1;
                  last_due = m_due;
                  m_r.addr = miss_addr + 32'(grants);
                  m_r.due  = m_due;
                  ret_q.push_back(m_r);
                  grants++;
               end
               if (m_rv && ret_q.size() > 0) begin
                  void'(ret_q.pop_front());
                  returns++;
                  if (returns == 4) begin
                     miss_active = 1'b0;
                     done_cycle  = 1'b1;
                     m_valid[miss_addr[8:2]] = 1'b1;
                     m_tag[miss_addr[8:2]]   = miss_addr[16:9];
                     resp_pending = !drop;
                     resp_data    = ram_word(miss_addr);
                  end
               end
            end
         end
      end
   end

   task automatic do_req(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk_in);
         if (req_ready_o) ok = 1'b1;
         @(posedge clk_in);
         #1;
      end
      req_valid_i = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL req_accept: request %h not accepted within 50 cycles", a);
      end
   endtask

   task automatic wait_resp(input string name, input int max, input int exp_lat, input logic [31:0] exp_data);
      int start;
      int i;
      start = resp_cnt;
      i = 0;
      while (resp_cnt == start && i < max) begin
         @(posedge clk_in);
         i++;
      end
      #1;
      check({name, "_seen"}, {31'd0, resp_cnt != start}, 32'd1);
      if (resp_cnt != start) begin
         check({name, "_latency"}, 32'(last_resp_cyc - acc_cyc), 32'(exp_lat));
         check({name, "_data"}, last_resp_data, exp_data);
         $display("resp %s: inst %h latency %0d", name, last_resp_data, last_resp_cyc - acc_cyc);
      end
   endtask

   int s, m;
   logic [31:0] ra;

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i = '0;
      flush_i = 1'b0;
      for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
      ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
      ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
      ram[8] = 8'h78; ram[9] = 8'h56; ram[10] = 8'h34; ram[11] = 8'h12;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Cold miss, then the same fetch as a hit.
      mc_req_cycles = 0;
      do_req(32'h0);
      wait_resp("cold_miss", 20, 6, 32'h0000_0013);
      check("cold_miss_mc_req_cycles", 32'(mc_req_cycles), 32'd4);
      m = mc_req_cycles;
      do_req(32'h0);
      wait_resp("hit", 5, 1, 32'h0000_0013);
      check("hit_no_mc_req", 32'(mc_req_cycles - m), 32'd0);

      // Conflicting tag on the same index evicts, then 0x0 must refill again.
      do_req(32'h200);
      wait_resp("conflict_miss", 20, 6, 32'h0010_0093);
      do_req(32'h0);
      wait_resp("refill_again", 20, 6, 32'h0000_0013);

      // Flush while the second byte returns: no response, but the line still fills.
      s = resp_cnt;
      do_req(32'h4);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      flush_i = 1'b1;
      @(posedge clk_in); #1;
      flush_i = 1'b0;
      repeat (8) @(posedge clk_in);
      #1;
      check("flush_drop_resp_count", 32'(resp_cnt - s), 32'd0);
      m = mc_req_cycles;
      do_req(32'h4);
      wait_resp("hit_after_flush", 5, 1, ram_word(32'h4));
      check("hit_after_flush_no_mc_req", 32'(mc_req_cycles - m), 32'd0);

      // Three frozen cycles mid-refill push the response out by three.
      do_req(32'h8);
      @(posedge clk_in); #1;
      rdy_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 rdy_in = 1'b1;
      wait_resp("rdy_stall", 20, 9, 32'h1234_5678);

      // Reset mid-refill, a late byte afterwards, then 0x0 must miss again.
      do_req(32'hC);
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      @(posedge clk_in);
      @(posedge clk_in); #2;
      rst_in = 1'b0;
      force_stray = 1'b1;
      @(posedge clk_in); #3;
      force_stray = 1'b0;
      @(posedge clk_in); #1;
      m = mc_req_cycles;
      do_req(32'h0);
      wait_resp("after_reset_miss", 20, 6, 32'h0000_0013);
      check("after_reset_mc_req_cycles", 32'(mc_req_cycles - m), 32'd4);

      // Randomized traffic on a few indices/tags with flushes, stalls, random grants.
      rand_mem = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rdy_in      = ($urandom_range(0, 9) != 0);
         flush_i     = ($urandom_range(0, 11) == 0);
         req_valid_i = ($urandom_range(0, 2) != 0);
         ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         req_addr_i  = ra;
         @(posedge clk_in);
         #1;
      end
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      rdy_in = 1'b1;
      repeat (40) @(posedge clk_in);
      #1;
      check("drained_idle", {31'd0, req_ready_o}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
